// File: rtl/board_line_clear.sv
`default_nettype none
// ============================================================================
//  Module      : board_line_clear
//  Description : Row-clear engine for the playfield board RAM. On start it
//                scans the board bottom-up, removes every full row, shifts
//                surviving rows down, zero-fills the vacated top rows and
//                reports how many rows were removed.
//  Ports       : clk, rst_n (async, active-low)
//                start      - one-cycle pass request (ignored unless idle)
//                busy       - pass in progress
//                done       - one-cycle completion pulse
//                lines      - rows cleared by the last pass
//                rd_addr/rd_data              - board RAM read port (1-cycle latency)
//                wr_addr/wr_data/wr_en/wr_byte_en - board RAM write port
//  Revision    : 1.0 - initial release
// ============================================================================
module board_line_clear #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int ADDR_W = 11,
    parameter int CELL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              wr_en,
    output logic [3:0]        wr_byte_en
);

    // Row pointers are signed so they can step past row 0 to -1.
    localparam int PTR_W = 6;
    localparam int COL_W = $clog2(COLS + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_FILL  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;
    logic signed [PTR_W-1:0] r_src;
    logic signed [PTR_W-1:0] r_dst;
    logic [COL_W-1:0]        r_col;
    logic [4:0]              r_lines;
    logic [CELL_W-1:0]       r_buf [COLS];

    logic signed [PTR_W-1:0] w_src_dec;
    logic signed [PTR_W-1:0] w_dst_dec;
    logic                    w_col_last;
    logic                    w_col_end;
    logic                    w_full;
    logic [COL_W-1:0]        w_buf_idx;
    logic [ADDR_W-1:0]       w_src_base;
    logic [ADDR_W-1:0]       w_dst_base;
    logic                    w_unused_rd_hi;

    assign w_src_dec  = r_src - PTR_W'(1);
    assign w_dst_dec  = r_dst - PTR_W'(1);
    assign w_col_last = (r_col == COL_W'(COLS - 1));
    assign w_col_end  = (r_col == COL_W'(COLS));
    // Read data lags the address by one cycle, so cycle c fills cell c-1.
    assign w_buf_idx  = r_col - COL_W'(1);
    // Pointers are only used as addresses while non-negative.
    assign w_src_base = ADDR_W'($unsigned(r_src)) * ADDR_W'(COLS);
    assign w_dst_base = ADDR_W'($unsigned(r_dst)) * ADDR_W'(COLS);
    assign lines      = r_lines;
    // Palette bits above the cell field carry no occupancy information.
    assign w_unused_rd_hi = ^rd_data[31:CELL_W];

    always_comb begin
        w_full = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (r_buf[i] == '0) begin
                w_full = 1'b0;
            end
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_READ;
                end
            end
            c_READ: begin
                if (w_col_end) begin
                    w_next_state = c_CHECK;
                end
            end
            c_CHECK: begin
                if (w_full) begin
                    // A cleared row leaves dst at or above row 0, so
                    // running out of source rows always needs a fill.
                    w_next_state = w_src_dec[PTR_W-1] ? c_FILL : c_READ;
                end else if (r_dst != r_src) begin
                    w_next_state = c_WRITE;
                end else begin
                    w_next_state = w_src_dec[PTR_W-1] ? c_DONE : c_READ;
                end
            end
            c_WRITE: begin
                if (w_col_last) begin
                    if (!w_src_dec[PTR_W-1]) begin
                        w_next_state = c_READ;
                    end else begin
                        w_next_state = w_dst_dec[PTR_W-1] ? c_DONE : c_FILL;
                    end
                end
            end
            c_FILL: begin
                if (w_col_last && w_dst_dec[PTR_W-1]) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_col   <= '0;
            r_lines <= '0;
            for (int i = 0; i < COLS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_src   <= PTR_W'(ROWS - 1);
                        r_dst   <= PTR_W'(ROWS - 1);
                        r_col   <= '0;
                        r_lines <= '0;
                    end
                end
                c_READ: begin
                    if (r_col != '0) begin
                        r_buf[w_buf_idx] <= rd_data[CELL_W-1:0];
                    end
                    r_col <= w_col_end ? '0 : r_col + COL_W'(1);
                end
                c_CHECK: begin
                    r_col <= '0;
                    if (w_full) begin
                        if (r_lines != 5'(ROWS)) begin
                            r_lines <= r_lines + 5'd1;
                        end
                        r_src <= w_src_dec;
                    end else if (r_dst == r_src) begin
                        // Row already in place: no rewrite needed.
                        r_src <= w_src_dec;
                        r_dst <= w_dst_dec;
                    end
                end
                c_WRITE: begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_src <= w_src_dec;
                        r_dst <= w_dst_dec;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                c_FILL: begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_dst <= w_dst_dec;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy       = (r_state != c_IDLE);
        done       = (r_state == c_DONE);
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_en      = 1'b0;
        wr_byte_en = 4'b1111;
        case (r_state)
            c_READ: begin
                if (!w_col_end) begin
                    rd_addr = w_src_base + ADDR_W'(r_col);
                end
            end
            c_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = w_dst_base + ADDR_W'(r_col);
                wr_data = 32'(r_buf[r_col]);
            end
            c_FILL: begin
                wr_en   = 1'b1;
                wr_addr = w_dst_base + ADDR_W'(r_col);
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_board_line_clear.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_line_clear
//  Description : Scoreboard bench for board_line_clear with a board RAM model
//                and a row-compaction reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_line_clear;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int ADDR_W = 11;
    localparam int CELL_W = 4;
    localparam int NCELL  = ROWS * COLS;
    localparam int BW     = NCELL * 32;

    typedef struct packed {
        logic [BW-1:0] board;
        logic [31:0]   lines;
        logic [31:0]   lat;
        logic [31:0]   nwr;
        logic [31:0]   t0;
        logic [31:0]   w0;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [4:0]        lines;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_en;
    logic [3:0]        wr_byte_en;

    logic [31:0]   mem [NCELL];
    logic          load;
    logic [BW-1:0] init_vec;
    int            cyc      = 0;
    int            wr_cnt   = 0;
    int            be_err   = 0;
    int            done_cnt = 0;
    int            checks   = 0;
    int            errors   = 0;
    exp_t          sb_q[$];

    board_line_clear #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CELL_W(CELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .lines(lines), .rd_addr(rd_addr), .rd_data(rd_q), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .wr_byte_en(wr_byte_en)
    );

    always #10 clk = ~clk;

    // Board RAM: synchronous read, one-cycle latency.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NCELL; i++) mem[i] <= init_vec[i*32 +: 32];
        end else if (wr_en && int'(wr_addr) < NCELL) begin
            mem[int'(wr_addr)] <= wr_data;
        end
        rd_q <= (int'(rd_addr) < NCELL) ? mem[int'(rd_addr)] : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (wr_byte_en != 4'hF) be_err <= be_err + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: survivors keep bottom-up order and sink to the bottom; rows
    // that move are rewritten with only the cell field, rows that stay are
    // untouched, everything above the survivors becomes zero.
    function automatic void model(input logic [BW-1:0] bin, output logic [BW-1:0] bout,
                                  output int nl, output int nm);
        int d;
        d = ROWS - 1; nl = 0; nm = 0; bout = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            bit full;
            full = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (bin[(r*COLS+c)*32 +: CELL_W] == '0) full = 1'b0;
            if (full) begin
                nl++;
            end else begin
                for (int c = 0; c < COLS; c++) begin
                    if (d == r) bout[(d*COLS+c)*32 +: 32] = bin[(r*COLS+c)*32 +: 32];
                    else        bout[(d*COLS+c)*32 +: 32] = {28'd0, bin[(r*COLS+c)*32 +: CELL_W]};
                end
                if (d != r) nm++;
                d--;
            end
        end
    endfunction

    // Monitor: pops the scoreboard whenever the engine signals completion.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected no pass pending");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("lines", 64'(lines), 64'(e.lines));
                chk("done_latency", 64'(cyc - int'(e.t0)), 64'(e.lat));
                chk("write_count", 64'(wr_cnt - int'(e.w0)), 64'(e.nwr));
                chk("byte_enable_errors", 64'(be_err), 64'd0);
                for (int r = 0; r < ROWS; r++) begin
                    int nbad; int fc;
                    nbad = 0; fc = 0;
                    for (int c = COLS - 1; c >= 0; c--)
                        if (mem[r*COLS+c] !== e.board[(r*COLS+c)*32 +: 32]) begin nbad++; fc = c; end
                    checks++;
                    if (nbad != 0) begin
                        errors++;
                        $display("FAIL board_row %0d: %0d cells differ, col %0d got %h expected %h",
                                 r, nbad, fc, mem[r*COLS+fc], e.board[(r*COLS+fc)*32 +: 32]);
                    end
                end
            end
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic load_board(input logic [BW-1:0] b);
        @(negedge clk); init_vec = b; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic run_pass(input logic [BW-1:0] b, input bit poke);
        exp_t e; logic [BW-1:0] bo; int nl; int nm; int dc0; int k;
        load_board(b);
        model(b, bo, nl, nm);
        e.board = bo; e.lines = 32'(nl);
        e.lat = 32'(ROWS*(COLS+2) + COLS*(nm+nl) + 1);
        e.nwr = 32'(COLS*(nm+nl));
        @(negedge clk);
        e.t0 = 32'(cyc); e.w0 = 32'(wr_cnt); dc0 = done_cnt;
        sb_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (poke) begin
            repeat (50) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == dc0 && k < 3000) begin @(negedge clk); k++; end
        if (k >= 3000) begin
            checks++; errors++;
            $display("FAIL pass_timeout: got no done in %0d cycles expected done", k);
            sb_q.delete();
        end else begin
            @(negedge clk);
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("lines_held", 64'(lines), 64'(nl));
        end
    endtask

    function automatic logic [31:0] rand_word(input bit nz);
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:CELL_W] = '0;
        if (nz) begin
            if (w[CELL_W-1:0] == '0) w[CELL_W-1:0] = CELL_W'($urandom_range(1, 15));
        end else begin
            w[CELL_W-1:0] = '0;
        end
        return w;
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        for (int r = 0; r < ROWS; r++) begin
            int t;
            t = $urandom_range(0, 3);
            for (int c = 0; c < COLS; c++)
                b[(r*COLS+c)*32 +: 32] = rand_word(t == 3 ? bit'($urandom_range(0, 1)) : (t != 0));
            if (t == 3) b[(r*COLS + $urandom_range(0, COLS-1))*32 +: 32] = rand_word(1'b0);
        end
        return b;
    endfunction

    initial begin
        logic [BW-1:0] b;
        int k;
        rst_n = 1'b0; start = 1'b0; load = 1'b0; init_vec = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lines", 64'(lines), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        rst_n = 1'b1;

        // Empty board.
        b = '0;
        run_pass(b, 1'b0);
        // Bottom row full of 3s, row 18 has a single 5 at col 3.
        b = '0;
        for (int c = 0; c < COLS; c++) b[(19*COLS+c)*32 +: 32] = 32'd3;
        b[(18*COLS+3)*32 +: 32] = 32'd5;
        run_pass(b, 1'b0);
        // Bottom four rows full.
        b = '0;
        for (int r = 16; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) b[(r*COLS+c)*32 +: 32] = rand_word(1'b1);
        run_pass(b, 1'b0);
        // Rows 19 and 17 full, row 18 pattern A, row 16 pattern B.
        b = '0;
        for (int c = 0; c < COLS; c++) begin
            b[(19*COLS+c)*32 +: 32] = 32'(c + 1);
            b[(17*COLS+c)*32 +: 32] = 32'hF;
            b[(18*COLS+c)*32 +: 32] = (c % 2 == 0) ? 32'hA : 32'h0;
            b[(16*COLS+c)*32 +: 32] = (c % 3 == 0) ? 32'h0 : 32'hB;
        end
        run_pass(b, 1'b0);
        // Row of 0x10 words counts as empty; row above it is full.
        b = '0;
        for (int c = 0; c < COLS; c++) begin
            b[(19*COLS+c)*32 +: 32] = 32'h10;
            b[(18*COLS+c)*32 +: 32] = 32'h7;
        end
        b[(17*COLS+0)*32 +: 32] = 32'h9;
        run_pass(b, 1'b0);

        // Randomized boards, one with a START pulse mid-pass.
        for (int n = 0; n < 8; n++) run_pass(rand_board(), n == 2);

        // Reset during the write phase aborts the pass.
        b = '0;
        for (int c = 0; c < COLS; c++) begin
            b[(19*COLS+c)*32 +: 32] = 32'h2;
            b[(18*COLS+c)*32 +: 32] = (c == 4) ? 32'h0 : 32'h6;
        end
        load_board(b);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!wr_en && k < 500) begin @(negedge clk); k++; end
        if (k >= 500) begin
            checks++; errors++;
            $display("FAIL wait_write: got wr_en=0 for %0d cycles expected a write", k);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_lines", 64'(lines), 64'd0);
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Engine recovers after the abort.
        run_pass(rand_board(), 1'b0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
